rv32i_mc_core: RTL and testbench

//   Multi-cycle RV32I integer core driving a registered instruction ROM and a byte-addressed data RAM.

---
 rtl/rv32i_mc_core.sv | 228 ++++++++++++++++++++++
 tb/tb_rv32i_mc_core.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_core.sv
// rv32i_mc_core: multi-cycle RV32I core for a registered instruction ROM and a byte-addressed data RAM.
// Optional MUL support is enabled with `define RV_MUL_EN; without it every funct7=0000001 OP is a NOP.
module rv32i_mc_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_mem_out,
  output logic [31:0] addr,
  input  logic [31:0] d_mem_out,
  output logic [31:0] d_addr,
  output logic [31:0] d_mem_in,
  output logic        d_mem_wen,
  output logic [1:0]  write_data_size
);
  // state   | meaning
  // FETCH   | addr=pc, ROM samples it at the edge
  // DECODE  | ROM word valid; latched into IR, memory-side outputs registered for EXEC
  // EXEC    | ALU/branch/jump, rd write for non-loads, pc update
  // LOAD_WB | load data valid; extend and write rd
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, LOAD_WB} state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q;
  logic [31:0] rf_q [32];

  logic [31:0] inst;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] rs1_v, rs2_v;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        is_op, is_opimm, is_load, is_store;
  logic [1:0]  mem_size;

  // The decoder looks at the ROM word directly in DECODE so memory outputs can be registered for EXEC.
  assign inst  = (state_q == DECODE) ? i_mem_out : ir_q;
  assign opc   = inst[6:0];
  assign rd    = inst[11:7];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rs1_v = rf_q[inst[19:15]];
  assign rs2_v = rf_q[inst[24:20]];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {inst[31:12], 12'h000};

  assign is_op    = (opc == OPC_OP);
  assign is_opimm = (opc == OPC_OPIMM);
  assign is_load  = (opc == OPC_LOAD) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  assign is_store = (opc == OPC_STORE) && (f3 inside {3'd0, 3'd1, 3'd2});
  assign mem_size = f3[1:0] + 2'd1;

  logic        mul_sel;
  logic [31:0] mul_res;
`ifdef RV_MUL_EN
  assign mul_sel = is_op && (f7 == 7'b0000001) && (f3 == 3'b000);
  assign mul_res = rs1_v * rs2_v;
`else
  assign mul_sel = 1'b0;
  assign mul_res = 32'h0;
`endif

  logic [31:0] op_b, alu_res;
  logic        alu_ok, op_valid;
  assign op_b = is_op ? rs2_v : imm_i;

  always_comb begin
    alu_res = 32'h0;
    alu_ok  = 1'b0;
    case (f3)
      3'd0: begin
        alu_res = (is_op && inst[30]) ? rs1_v - op_b : rs1_v + op_b;
        alu_ok  = is_opimm || (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      3'd1: begin
        alu_res = rs1_v << op_b[4:0];
        alu_ok  = (f7 == 7'b0000000);
      end
      3'd2: begin
        alu_res = {31'h0, $signed(rs1_v) < $signed(op_b)};
        alu_ok  = is_opimm || (f7 == 7'b0000000);
      end
      3'd3: begin
        alu_res = {31'h0, rs1_v < op_b};
        alu_ok  = is_opimm || (f7 == 7'b0000000);
      end
      3'd4: begin
        alu_res = rs1_v ^ op_b;
        alu_ok  = is_opimm || (f7 == 7'b0000000);
      end
      3'd5: begin
        alu_res = inst[30] ? $unsigned($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
        alu_ok  = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      3'd6: begin
        alu_res = rs1_v | op_b;
        alu_ok  = is_opimm || (f7 == 7'b0000000);
      end
      default: begin
        alu_res = rs1_v & op_b;
        alu_ok  = is_opimm || (f7 == 7'b0000000);
      end
    endcase
  end

  assign op_valid = (is_op || is_opimm) && (alu_ok || mul_sel);

  logic br_take;
  always_comb begin
    br_take = 1'b0;
    case (f3)
      3'd0:    br_take = (rs1_v == rs2_v);
      3'd1:    br_take = (rs1_v != rs2_v);
      3'd4:    br_take = ($signed(rs1_v) < $signed(rs2_v));
      3'd5:    br_take = ($signed(rs1_v) >= $signed(rs2_v));
      3'd6:    br_take = (rs1_v < rs2_v);
      3'd7:    br_take = (rs1_v >= rs2_v);
      default: br_take = 1'b0;
    endcase
  end

  logic        wb_en;
  logic [31:0] wb_val;
  always_comb begin
    wb_en  = 1'b0;
    wb_val = alu_res;
    pc_d   = pc_q + 32'd4;
    case (opc)
      OPC_LUI: begin
        wb_en  = 1'b1;
        wb_val = imm_u;
      end
      OPC_AUIPC: begin
        wb_en  = 1'b1;
        wb_val = pc_q + imm_u;
      end
      OPC_JAL: begin
        wb_en  = 1'b1;
        wb_val = pc_q + 32'd4;
        pc_d   = pc_q + imm_j;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          wb_en  = 1'b1;
          wb_val = pc_q + 32'd4;
          pc_d   = (rs1_v + imm_i) & 32'hFFFF_FFFE;
        end
      end
      OPC_BRANCH: begin
        if (br_take) pc_d = pc_q + imm_b;
      end
      OPC_OPIMM, OPC_OP: begin
        wb_en  = op_valid;
        wb_val = mul_sel ? mul_res : alu_res;
      end
      default: ;
    endcase
  end

  logic [31:0] ld_val;
  always_comb begin
    case (f3)
      3'd0:    ld_val = {{24{d_mem_out[7]}}, d_mem_out[7:0]};
      3'd1:    ld_val = {{16{d_mem_out[15]}}, d_mem_out[15:0]};
      3'd4:    ld_val = {24'h0, d_mem_out[7:0]};
      3'd5:    ld_val = {16'h0, d_mem_out[15:0]};
      default: ld_val = d_mem_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= FETCH;
      pc_q            <= RESET_PC;
      ir_q            <= 32'h0;
      d_addr          <= 32'h0;
      d_mem_in        <= 32'h0;
      d_mem_wen       <= 1'b0;
      write_data_size <= 2'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
    end else begin
      case (state_q)
        FETCH: state_q <= DECODE;
        DECODE: begin
          ir_q    <= i_mem_out;
          state_q <= EXEC;
          if (is_store) begin
            d_mem_wen       <= 1'b1;
            d_addr          <= rs1_v + imm_s;
            d_mem_in        <= rs2_v;
            write_data_size <= mem_size;
          end else if (is_load) begin
            d_addr          <= rs1_v + imm_i;
            write_data_size <= mem_size;
          end
        end
        EXEC: begin
          d_mem_wen       <= 1'b0;
          write_data_size <= 2'd0;
          pc_q            <= pc_d;
          if (wb_en && (rd != 5'd0)) rf_q[rd] <= wb_val;
          state_q <= is_load ? LOAD_WB : FETCH;
        end
        default: begin
          if (rd != 5'd0) rf_q[rd] <= ld_val;
          state_q <= FETCH;
        end
      endcase
    end
  end

  assign addr = pc_q;

endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: small programs in a ROM model, stores captured and compared
// against hand-computed values.
module tb_rv32i_mc_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_mem_out = 32'h0;
  logic [31:0] d_mem_out = 32'h0;
  logic [31:0] addr, d_addr, d_mem_in;
  logic        d_mem_wen;
  logic [1:0]  write_data_size;

  logic [31:0] rom [64];
  logic [31:0] ld_data = 32'h0;
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0 = 0;
  int st_cnt = 0;
  int base = 0;
  logic [31:0] st_a [256];
  logic [31:0] st_d [256];
  logic [1:0]  st_s [256];
  int          st_c [256];

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  rv32i_mc_core dut (
    .clk             (clk),
    .reset           (reset),
    .i_mem_out       (i_mem_out),
    .addr            (addr),
    .d_mem_out       (d_mem_out),
    .d_addr          (d_addr),
    .d_mem_in        (d_mem_in),
    .d_mem_wen       (d_mem_wen),
    .write_data_size (write_data_size)
  );

  always @(posedge clk) begin
    i_mem_out <= rom[addr[7:2]];
    d_mem_out <= ld_data;
    cyc       <= cyc + 1;
  end

  always @(negedge clk) begin
    logic [7:0] ix;
    if (reset && d_mem_wen) begin
      ix       = st_cnt[7:0];
      st_a[ix] = d_addr;
      st_d[ix] = d_mem_in;
      st_s[ix] = write_data_size;
      st_c[ix] = cyc;
      st_cnt   = st_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic chk_store(input string tag, input int i, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] s);
    logic [7:0] ix;
    ix = 8'(base + i);
    chk({tag, "_addr"}, st_a[ix], a);
    chk({tag, "_data"}, st_d[ix], d);
    chk({tag, "_size"}, 32'(st_s[ix]), 32'(s));
  endtask

  task automatic chk_store_cyc(input string tag, input int i, input int exp);
    logic [7:0] ix;
    ix = 8'(base + i);
    chk(tag, 32'(st_c[ix] - t0), 32'(exp));
  endtask

  task automatic fill_nops();
    for (int i = 0; i < 64; i++) rom[i] = NOP;
  endtask

  task automatic start();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    base  = st_cnt;
    t0    = cyc;
    reset = 1'b1;
  endtask

  task automatic wait_stores(input string tag, input int n);
    int k;
    k = 0;
    while ((st_cnt - base) < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    chk({tag, "_store_count"}, 32'(st_cnt - base), 32'(n));
  endtask

  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] shift_i(input int f7, input int f3, input int rd, input int rs1, input int sh);
    return {7'(f7), 5'(sh), 5'(rs1), 3'(f3), 5'(rd), 7'b0010011};
  endfunction
  function automatic logic [31:0] lui(input int rd, input int imm20);
    return {20'(imm20), 5'(rd), 7'b0110111};
  endfunction
  function automatic logic [31:0] load(input int f3, input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'b0000011};
  endfunction
  function automatic logic [31:0] store(input int f3, input int rs2, input int rs1, input int imm);
    logic [11:0] im;
    im = 12'(imm);
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] branch(input int f3, input int rs1, input int rs2, input int imm);
    logic [12:0] im;
    im = 13'(imm);
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] jal(input int rd, input int imm);
    logic [20:0] im;
    im = 21'(imm);
    return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
  endfunction
  function automatic logic [31:0] jalr(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b1100111};
  endfunction
  function automatic logic [31:0] rtype(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] mul_exp;

    // Reset state and NOP stepping
    fill_nops();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr, 32'h0);
    chk("rst_wen", 32'(d_mem_wen), 32'h0);
    chk("rst_size", 32'(write_data_size), 32'h0);
    chk("rst_daddr", d_addr, 32'h0);
    chk("rst_dmemin", d_mem_in, 32'h0);
    @(negedge clk);
    base  = st_cnt;
    t0    = cyc;
    reset = 1'b1;
    @(posedge clk); #1 chk("nop_addr_c1", addr, 32'd0);
    repeat (2) @(posedge clk); #1 chk("nop_addr_c3", addr, 32'd4);
    repeat (3) @(posedge clk); #1 chk("nop_addr_c6", addr, 32'd8);
    chk("nop_no_store", 32'(st_cnt - base), 32'd0);

    // addi + sb
    fill_nops();
    rom[0] = addi(1, 0, 7);
    rom[1] = store(0, 1, 0, 3);
    start();
    wait_stores("sb", 1);
    chk_store("sb", 0, 32'd3, 32'd7, 2'd1);
    chk_store_cyc("sb_cycle", 0, 5);
    repeat (6) @(posedge clk);
    #1;
    chk("sb_single_strobe", 32'(st_cnt - base), 32'd1);
    chk("idle_size", 32'(write_data_size), 32'd0);

    // lb sign-extends and takes 4 cycles
    fill_nops();
    ld_data = 32'h0000_00F0;
    rom[0]  = load(0, 2, 0, 0);
    rom[1]  = store(2, 2, 0, 4);
    start();
    repeat (2) @(posedge clk);
    #1;
    chk("lb_exec_size", 32'(write_data_size), 32'd1);
    chk("lb_exec_wen", 32'(d_mem_wen), 32'd0);
    @(posedge clk);
    #1;
    chk("lb_wb_size", 32'(write_data_size), 32'd0);
    wait_stores("lb", 1);
    chk_store("lb", 0, 32'd4, 32'hFFFF_FFF0, 2'd3);
    chk_store_cyc("lb_cycle", 0, 6);

    // lbu zero-extends
    rom[0] = load(4, 2, 0, 0);
    start();
    wait_stores("lbu", 1);
    chk_store("lbu", 0, 32'd4, 32'h0000_00F0, 2'd3);

    // lh sign-extends from bit 15
    ld_data = 32'h0000_8001;
    rom[0]  = load(1, 2, 0, 2);
    start();
    repeat (2) @(posedge clk);
    #1;
    chk("lh_exec_size", 32'(write_data_size), 32'd2);
    chk("lh_exec_daddr", d_addr, 32'd2);
    wait_stores("lh", 1);
    chk_store("lh", 0, 32'd4, 32'hFFFF_8001, 2'd3);

    // branch not taken, jal, branch taken
    fill_nops();
    rom[0] = addi(3, 0, 1);
    rom[1] = branch(0, 3, 0, 8);
    rom[2] = jal(1, 16);
    rom[3] = store(2, 3, 0, 64);
    rom[4] = store(2, 3, 0, 64);
    rom[5] = store(2, 3, 0, 64);
    rom[6] = store(2, 1, 0, 0);
    rom[7] = branch(1, 3, 0, 8);
    rom[8] = store(2, 3, 0, 64);
    rom[9] = store(2, 3, 0, 8);
    start();
    repeat (6) @(posedge clk); #1 chk("beq_nt_addr", addr, 32'd8);
    repeat (3) @(posedge clk); #1 chk("jal_addr", addr, 32'd24);
    wait_stores("jmp", 2);
    chk_store("jal_link", 0, 32'd0, 32'd12, 2'd3);
    chk_store("bne_taken", 1, 32'd8, 32'd1, 2'd3);

    // x0 discard, srai, slt/sltu, srli
    fill_nops();
    rom[0]  = addi(0, 0, 5);
    rom[1]  = store(2, 0, 0, 0);
    rom[2]  = lui(7, 'h80000);
    rom[3]  = shift_i('h20, 5, 8, 7, 4);
    rom[4]  = store(2, 8, 0, 4);
    rom[5]  = addi(10, 0, -1);
    rom[6]  = rtype(0, 2, 11, 10, 0);
    rom[7]  = rtype(0, 3, 12, 10, 0);
    rom[8]  = store(2, 11, 0, 8);
    rom[9]  = store(2, 12, 0, 12);
    rom[10] = shift_i(0, 5, 14, 10, 28);
    rom[11] = store(2, 14, 0, 16);
    start();
    wait_stores("alu", 5);
    chk_store("x0", 0, 32'd0, 32'd0, 2'd3);
    chk_store("srai", 1, 32'd4, 32'hF800_0000, 2'd3);
    chk_store("slt", 2, 32'd8, 32'd1, 2'd3);
    chk_store("sltu", 3, 32'd12, 32'd0, 2'd3);
    chk_store("srli", 4, 32'd16, 32'h0000_000F, 2'd3);

    // mul (configuration dependent) and jalr
`ifdef RV_MUL_EN
    mul_exp = 32'd42;
`else
    mul_exp = 32'd0;
`endif
    fill_nops();
    rom[0]  = addi(4, 0, 6);
    rom[1]  = addi(5, 0, 7);
    rom[2]  = rtype(1, 0, 6, 4, 5);
    rom[3]  = store(2, 6, 0, 0);
    rom[4]  = addi(15, 0, 41);
    rom[5]  = jalr(16, 15, 0);
    rom[6]  = store(2, 4, 0, 64);
    rom[7]  = store(2, 4, 0, 64);
    rom[8]  = store(2, 4, 0, 64);
    rom[9]  = store(2, 4, 0, 64);
    rom[10] = store(2, 16, 0, 4);
    start();
    wait_stores("mul", 2);
    chk_store("mul", 0, 32'd0, mul_exp, 2'd3);
    chk_store("jalr_link", 1, 32'd4, 32'd24, 2'd3);

    // reset during a store EXEC aborts it at once
    fill_nops();
    rom[0] = addi(1, 0, 9);
    rom[1] = store(2, 1, 0, 12);
    start();
    repeat (5) @(posedge clk);
    #1;
    chk("pre_abort_wen", 32'(d_mem_wen), 32'd1);
    chk("pre_abort_daddr", d_addr, 32'd12);
    reset = 1'b0;
    #1;
    chk("abort_wen", 32'(d_mem_wen), 32'd0);
    chk("abort_size", 32'(write_data_size), 32'd0);
    chk("abort_daddr", d_addr, 32'd0);
    chk("abort_addr", addr, 32'd0);
    @(negedge clk);
    chk("abort_no_store", 32'(st_cnt - base), 32'd0);

    // registers cleared by reset
    fill_nops();
    rom[0] = store(2, 1, 0, 0);
    start();
    wait_stores("rst_x1", 1);
    chk_store("rst_x1", 0, 32'd0, 32'd0, 2'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
